// File: rtl/pkt_switch_pkg.sv
// rtl/pkt_switch_pkg.sv - shared constants, state enum and round-robin helper for the packet switch
package pkt_switch_pkg;

    localparam int unsigned NUM_INGRESS = 3;

    localparam logic [31:0] IP_PORT_A = 32'hC0A8_010A;
    localparam logic [31:0] IP_PORT_B = 32'hC0A8_010B;
    localparam logic [31:0] IP_PORT_C = 32'hC0A8_010C;

    localparam logic [1:0] PORT_A     = 2'd0;
    localparam logic [1:0] PORT_B     = 2'd1;
    localparam logic [1:0] PORT_C     = 2'd2;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p >= PORT_C) ? PORT_A : p + 2'd1;
    endfunction

    // First set bit of mask, scanning upward from ptr+1 and wrapping modulo 3.
    function automatic rr_pick_t rr_pick(input logic [2:0] mask, input logic [1:0] ptr);
        rr_pick_t   res;
        logic [1:0] idx;
        res.found = 1'b0;
        res.idx   = GRANT_NONE;
        idx       = ptr;
        for (int k = 0; k < 3; k++) begin
            idx = next_port(idx);
            if (!res.found && mask[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ip_port_mapper.sv
// rtl/ip_port_mapper.sv - decodes a destination IP into an egress port select plus invalid flag
module ip_port_mapper
    import pkt_switch_pkg::*;
(
    input  logic [31:0] ip,
    output logic [1:0]  port,
    output logic        invalid
);

    always_comb begin
        port    = GRANT_NONE;
        invalid = 1'b1;
        case (ip)
            IP_PORT_A: begin
                port    = PORT_A;
                invalid = 1'b0;
            end
            IP_PORT_B: begin
                port    = PORT_B;
                invalid = 1'b0;
            end
            IP_PORT_C: begin
                port    = PORT_C;
                invalid = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/egress_rr_arbiter.sv
// rtl/egress_rr_arbiter.sv - packet-granular round-robin arbiter feeding one egress port, with optional drop of unroutable packets
module egress_rr_arbiter #(
    parameter int unsigned EGRESS_PORT   = 0,
    parameter bit          DROP_EN       = 1'b0,
    parameter logic [15:0] DROP_CNT_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  in_req,
    input  logic [31:0] in_dst_ip0,
    input  logic [31:0] in_dst_ip1,
    input  logic [31:0] in_dst_ip2,
    input  logic [2:0]  in_valid,
    input  logic [2:0]  in_last,
    input  logic [31:0] in_data0,
    input  logic [31:0] in_data1,
    input  logic [31:0] in_data2,
    output logic [2:0]  in_ready,
    output logic        out_valid,
    output logic        out_last,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic [1:0]  grant_id,
    output logic [15:0] drop_cnt
);

    import pkt_switch_pkg::*;

    localparam logic [1:0] EGRESS_SEL = 2'(EGRESS_PORT);

    arb_state_t  state, state_nx;
    logic [1:0]  grant, grant_nx;
    logic [1:0]  rr_ptr, rr_ptr_nx;
    logic        drop_done;

    logic [31:0] dst_ip   [NUM_INGRESS];
    logic [1:0]  port_sel [NUM_INGRESS];
    logic [2:0]  ip_invalid;
    logic [2:0]  elig;
    logic [2:0]  drop_elig;
    rr_pick_t    pick_fwd;
    rr_pick_t    pick_drop;

    logic        g_valid;
    logic        g_last;
    logic [31:0] g_data;
    logic [2:0]  grant_onehot;

    assign dst_ip[0] = in_dst_ip0;
    assign dst_ip[1] = in_dst_ip1;
    assign dst_ip[2] = in_dst_ip2;

    for (genvar i = 0; i < NUM_INGRESS; i++) begin : g_map
        ip_port_mapper u_map (
            .ip      (dst_ip[i]),
            .port    (port_sel[i]),
            .invalid (ip_invalid[i])
        );
    end

    always_comb begin
        elig      = '0;
        drop_elig = '0;
        for (int i = 0; i < NUM_INGRESS; i++) begin
            elig[i]      = in_req[i] && !ip_invalid[i] && (port_sel[i] == EGRESS_SEL);
            drop_elig[i] = in_req[i] && ip_invalid[i] && DROP_EN;
        end
    end

    assign pick_fwd  = rr_pick(elig, rr_ptr);
    assign pick_drop = rr_pick(drop_elig, rr_ptr);

    // Granted-ingress beat mux; GRANT_NONE selects nothing.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        case (grant)
            PORT_A: begin
                g_valid = in_valid[0];
                g_last  = in_last[0];
                g_data  = in_data0;
            end
            PORT_B: begin
                g_valid = in_valid[1];
                g_last  = in_last[1];
                g_data  = in_data1;
            end
            PORT_C: begin
                g_valid = in_valid[2];
                g_last  = in_last[2];
                g_data  = in_data2;
            end
            default: ;
        endcase
    end

    assign grant_onehot = 3'b001 << grant;
    assign grant_id     = grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= GRANT_NONE;
            rr_ptr   <= PORT_C;
            drop_cnt <= DROP_CNT_INIT;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            rr_ptr <= rr_ptr_nx;
            if (drop_done && (drop_cnt != DROP_CNT_MAX)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        rr_ptr_nx = rr_ptr;
        drop_done = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        in_ready  = '0;
        case (state)
            ST_IDLE: begin
                // Routable traffic always wins over discards in the same cycle.
                if (pick_fwd.found) begin
                    state_nx = ST_FWD;
                    grant_nx = pick_fwd.idx;
                end else if (pick_drop.found) begin
                    state_nx = ST_DROP;
                    grant_nx = pick_drop.idx;
                end
            end
            ST_FWD: begin
                out_valid = g_valid;
                out_last  = g_last;
                out_data  = g_data;
                in_ready  = grant_onehot & {3{out_ready}};
                if (g_valid && out_ready && g_last) begin
                    state_nx  = ST_IDLE;
                    grant_nx  = GRANT_NONE;
                    rr_ptr_nx = grant;
                end
            end
            ST_DROP: begin
                in_ready = grant_onehot;
                if (g_valid && g_last) begin
                    state_nx  = ST_IDLE;
                    grant_nx  = GRANT_NONE;
                    rr_ptr_nx = grant;
                    drop_done = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = GRANT_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_egress_rr_arbiter.sv
// tb/tb_egress_rr_arbiter.sv - scoreboard bench for egress_rr_arbiter
module tb_egress_rr_arbiter;

    localparam logic [31:0] IP_A   = 32'hC0A8_010A;
    localparam logic [31:0] IP_B   = 32'hC0A8_010B;
    localparam logic [31:0] IP_BAD = 32'h0A00_0001;

    logic        clk;
    logic        reset;
    logic [2:0]  in_req;
    logic [31:0] dst [3];
    logic [2:0]  in_valid;
    logic [2:0]  in_last;
    logic [31:0] din [3];
    logic [2:0]  in_ready;
    logic        out_valid;
    logic        out_last;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  grant_id;
    logic [15:0] drop_cnt;

    logic [2:0]  sat_in_ready;
    logic        sat_out_valid;
    logic        sat_out_last;
    logic [31:0] sat_out_data;
    logic [1:0]  sat_grant_id;
    logic [15:0] sat_drop_cnt;

    egress_rr_arbiter #(.EGRESS_PORT(0), .DROP_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_req(in_req),
        .in_dst_ip0(dst[0]), .in_dst_ip1(dst[1]), .in_dst_ip2(dst[2]),
        .in_valid(in_valid), .in_last(in_last),
        .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]),
        .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last),
        .out_data(out_data), .out_ready(out_ready), .grant_id(grant_id),
        .drop_cnt(drop_cnt)
    );

    // Same stimulus, counter preset near the top to reach saturation quickly.
    egress_rr_arbiter #(.EGRESS_PORT(0), .DROP_EN(1'b1), .DROP_CNT_INIT(16'hFFFE)) dut_sat (
        .clk(clk), .reset(reset), .in_req(in_req),
        .in_dst_ip0(dst[0]), .in_dst_ip1(dst[1]), .in_dst_ip2(dst[2]),
        .in_valid(in_valid), .in_last(in_last),
        .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]),
        .in_ready(sat_in_ready), .out_valid(sat_out_valid), .out_last(sat_out_last),
        .out_data(sat_out_data), .out_ready(out_ready), .grant_id(sat_grant_id),
        .drop_cnt(sat_drop_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  gid;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    beats_seen = 0;
    bit    drop_phase = 0;
    bit    drop_saw_valid = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_pkt(input int i, input int n, input logic [31:0] base);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + 32'(k);
            b.last = (k == n - 1);
            b.gid  = 2'(i);
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && drop_phase && out_valid) drop_saw_valid = 1'b1;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: got data %0h expected no beat", out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_last", 32'(out_last), 32'(e.last));
                check("beat_gid", 32'(grant_id), 32'(e.gid));
            end
            beats_seen++;
        end
    end

    task automatic send(input int i, input logic [31:0] ip, input int n,
                        input logic [31:0] base, output int stall);
        stall = 0;
        @(posedge clk); #1;
        in_req[i] = 1'b1;
        dst[i]    = ip;
        for (int b = 0; b < n; b++) begin
            bit got;
            in_valid[i] = 1'b1;
            din[i]      = base + 32'(b);
            in_last[i]  = (b == n - 1);
            got = 0;
            while (!got) begin
                @(negedge clk);
                if (in_ready[i]) got = 1;
                else begin
                    stall++;
                    if (stall > 60) begin
                        checks++;
                        $display("FAIL send_timeout: ingress %0d got no ready expected ready within 60 cycles", i);
                        in_req[i] = 1'b0; in_valid[i] = 1'b0; in_last[i] = 1'b0;
                        return;
                    end
                    @(posedge clk); #1;
                end
            end
            @(posedge clk); #1;
        end
        in_req[i]   = 1'b0;
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded expected completion");
        $fatal(1);
    end

    initial begin
        int  s0, s1, s2;
        bit  bad;
        int  start;
        bit  reached;

        reset = 1'b1; in_req = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin dst[i] = '0; din[i] = '0; end
        #1;
        check("rst_grant", 32'(grant_id), 32'd3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_sat_drop_cnt", 32'(sat_drop_cnt), 32'hFFFE);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Three simultaneous 2-beat requests: served 0,1,2.
        push_pkt(0, 2, 32'h0000_0A00);
        push_pkt(1, 2, 32'h0000_0B00);
        push_pkt(2, 2, 32'h0000_0C00);
        fork
            send(0, IP_A, 2, 32'h0000_0A00, s0);
            send(1, IP_A, 2, 32'h0000_0B00, s1);
            send(2, IP_A, 2, 32'h0000_0C00, s2);
        join
        check("rr_stall0", 32'(s0), 32'd1);
        check("rr_stall1", 32'(s1), 32'd4);
        check("rr_stall2", 32'(s2), 32'd7);
        check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure on a 4-beat packet.
        push_pkt(1, 4, 32'h0000_1100);
        fork
            send(1, IP_A, 4, 32'h0000_1100, s1);
            begin
                start = beats_seen;
                reached = 0;
                for (int k = 0; k < 20 && !reached; k++) begin
                    @(posedge clk); #1;
                    if (beats_seen == start + 1) reached = 1;
                end
                check("bp_first_beat_seen", 32'(reached), 32'd1);
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_grant", 32'(grant_id), 32'd1);
                    check("bp_valid_held", 32'(out_valid), 32'd1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        check("bp_stall", 32'(s1), 32'd4);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Invalid IP dropped.
        check("drop_cnt_before", 32'(drop_cnt), 32'd0);
        drop_saw_valid = 0;
        drop_phase = 1;
        send(2, IP_BAD, 3, 32'h0000_2200, s2);
        drop_phase = 0;
        check("drop_stall", 32'(s2), 32'd1);
        check("drop_no_out_valid", 32'(drop_saw_valid), 32'd0);
        check("drop_cnt_after", 32'(drop_cnt), 32'd1);
        check("sat_drop_cnt_top", 32'(sat_drop_cnt), 32'hFFFF);

        // Request for another egress never granted.
        @(posedge clk); #1;
        in_req[0] = 1'b1; dst[0] = IP_B; in_valid[0] = 1'b1; din[0] = 32'h0000_3000; in_last[0] = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (grant_id !== 2'd3 || in_ready !== 3'b000 || out_valid !== 1'b0) bad = 1;
        end
        check("other_port_never_granted", 32'(bad), 32'd0);
        @(posedge clk); #1;
        in_req = '0; in_valid = '0; in_last = '0;

        // Reset in the middle of a 5-beat packet.
        @(posedge clk); #1;
        push_pkt(1, 1, 32'h0000_5500);
        exp_q[exp_q.size()-1].last = 1'b0;
        in_req[1] = 1'b1; dst[1] = IP_A; in_valid[1] = 1'b1; din[1] = 32'h0000_5500; in_last[1] = 1'b0;
        reached = 0;
        for (int k = 0; k < 10 && !reached; k++) begin
            @(negedge clk);
            if (in_ready[1]) reached = 1;
        end
        check("mid_pkt_beat0_ready", 32'(reached), 32'd1);
        @(posedge clk); #1;
        din[1] = 32'h0000_5501;
        #1 reset = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant_id), 32'd3);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("async_rst_sat_drop_cnt", 32'(sat_drop_cnt), 32'hFFFE);
        check("async_rst_queue_empty", 32'(exp_q.size()), 32'd0);
        in_req = '0; in_valid = '0; in_last = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // After reset ingress 0 wins first; single-beat packets.
        push_pkt(0, 1, 32'h0000_6600);
        push_pkt(1, 1, 32'h0000_6610);
        fork
            send(0, IP_A, 1, 32'h0000_6600, s0);
            send(1, IP_A, 1, 32'h0000_6610, s1);
        join
        check("post_rst_stall0", 32'(s0), 32'd1);
        check("post_rst_stall1", 32'(s1), 32'd3);
        check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Forward beats drop in the same cycle; counter saturation.
        push_pkt(1, 1, 32'h0000_7710);
        fork
            send(0, IP_BAD, 1, 32'h0000_7700, s0);
            send(1, IP_A, 1, 32'h0000_7710, s1);
        join
        check("prio_fwd_stall", 32'(s1), 32'd1);
        check("prio_drop_stall", 32'(s0), 32'd3);
        check("prio_drop_cnt", 32'(drop_cnt), 32'd1);
        check("sat_reach", 32'(sat_drop_cnt), 32'hFFFF);
        send(0, IP_BAD, 1, 32'h0000_7720, s0);
        check("drop2_stall", 32'(s0), 32'd1);
        check("drop2_cnt", 32'(drop_cnt), 32'd2);
        check("sat_hold", 32'(sat_drop_cnt), 32'hFFFF);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
